// File: rtl/d5m_axis_packer_pkg.sv
// Shared types and defaults for the D5M raw-bus to AXI4-Stream capture stage.
package d5m_axis_packer_pkg;

   localparam int D5M_DATA_WIDTH  = 12;
   localparam int PIX_FIFO_DEPTH  = 16;
   localparam int PIX_TDATA_WIDTH = 16;

   typedef struct packed {
      logic                       tuser;
      logic                       tlast;
      logic [PIX_TDATA_WIDTH-1:0] data;
   } pix_entry_t;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      ACTIVE   = 2'd1,
      DROP     = 2'd2
   } capture_state_t;

   function automatic int cnt_bits(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/d5m_axis_packer_fifo.sv
// First-word-fall-through pixel FIFO with a registered head stage.
module axis_pixel_fifo
   import d5m_axis_packer_pkg::*;
#(
   parameter type T     = pix_entry_t,
   parameter int  DEPTH = PIX_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = cnt_bits(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  T              wr_data,
   input  logic          rd_en,
   output T              rd_data,
   output logic          rd_valid,
   output logic [CW-1:0] count
);

   T              mem_q [DEPTH];
   T              head_q, head_d;
   logic          head_vld_q, head_vld_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] mem_cnt_q, mem_cnt_d;
   logic          pop;
   logic          load;

   always_comb begin
      pop        = rd_en & head_vld_q;
      load       = (pop | ~head_vld_q) & (mem_cnt_q != '0);
      wr_ptr_d   = wr_ptr_q + AW'(wr_en);
      rd_ptr_d   = rd_ptr_q + AW'(load);
      mem_cnt_d  = mem_cnt_q + CW'(wr_en) - CW'(load);
      head_d     = head_q;
      head_vld_d = head_vld_q;
      if (load) begin
         head_d     = mem_q[rd_ptr_q];
         head_vld_d = 1'b1;
      end else if (pop) begin
         head_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q     <= '0;
         head_vld_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mem_cnt_q  <= '0;
      end else begin
         head_q     <= head_d;
         head_vld_q <= head_vld_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mem_cnt_q  <= mem_cnt_d;
      end
   end

   assign rd_data  = head_q;
   assign rd_valid = head_vld_q;
   assign count    = mem_cnt_q + CW'(head_vld_q);

endmodule

// File: rtl/d5m_axis_packer.sv
// D5M camera raw bus to AXI4-Stream video packer with frame/line statistics.
module d5m_axis_packer
   import d5m_axis_packer_pkg::*;
#(
   parameter int DATA_WIDTH  = D5M_DATA_WIDTH,
   parameter int TDATA_WIDTH = PIX_TDATA_WIDTH,
   parameter int FIFO_DEPTH  = PIX_FIFO_DEPTH,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   pixclk,
   input  logic                   pixrst,
   input  logic                   ifval,
   input  logic                   ilval,
   input  logic [DATA_WIDTH-1:0]  idata,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tvalid,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tuser,
   output logic                   m_axis_tlast,
   input  logic                   ovf_clr,
   output logic                   overflow,
   output logic [CNT_WIDTH-1:0]   line_width,
   output logic [CNT_WIDTH-1:0]   frame_lines,
   output logic [CNT_WIDTH-1:0]   frame_cnt
);

   localparam int CW = cnt_bits(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   typedef struct packed {
      logic                   tuser;
      logic                   tlast;
      logic [TDATA_WIDTH-1:0] data;
   } entry_t;

   capture_state_t         state_q, state_d;
   logic                   ifval_q;
   logic                   sof_q, sof_d;
   logic                   pend_vld_q, pend_vld_d;
   logic                   pend_user_q, pend_user_d;
   logic [TDATA_WIDTH-1:0] pend_data_q, pend_data_d;
   logic [TDATA_WIDTH-1:0] pix_ext;
   logic [CNT_WIDTH-1:0]   pix_cnt_q, pix_cnt_d;
   logic [CNT_WIDTH-1:0]   line_cnt_q, line_cnt_d;
   logic [CNT_WIDTH-1:0]   line_width_q, line_width_d;
   logic [CNT_WIDTH-1:0]   frame_lines_q, frame_lines_d;
   logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   ovf_set;
   logic                   fval_rise, fval_fall, cap;
   logic                   wr_last, wr_en;
   entry_t                 wr_entry, head;
   logic                   head_vld;
   logic [CW-1:0]          fifo_cnt;

   always_comb begin
      pix_ext                 = '0;
      pix_ext[DATA_WIDTH-1:0] = idata;
      fval_rise     = ifval & ~ifval_q;
      fval_fall     = ~ifval & ifval_q;
      cap           = ifval & ilval;
      state_d       = state_q;
      sof_d         = sof_q;
      pend_vld_d    = pend_vld_q;
      pend_user_d   = pend_user_q;
      pend_data_d   = pend_data_q;
      pix_cnt_d     = pix_cnt_q;
      line_cnt_d    = line_cnt_q;
      line_width_d  = line_width_q;
      frame_lines_d = frame_lines_q;
      frame_cnt_d   = frame_cnt_q;
      ovf_set       = 1'b0;
      wr_en         = 1'b0;
      wr_last       = ~cap;
      wr_entry      = '{tuser: pend_user_q, tlast: 1'b0, data: pend_data_q};

      unique case (state_q)
         WAIT_SOF: begin
            if (fval_rise) begin
               state_d = ACTIVE;
               sof_d   = 1'b1;
            end
         end
         ACTIVE: begin
            if (fval_rise) begin
               sof_d = 1'b1;
            end
            if (pend_vld_q) begin
               if (fifo_cnt == CW'(FIFO_DEPTH)) begin
                  ovf_set    = 1'b1;
                  pix_cnt_d  = '0;
                  pend_vld_d = 1'b0;
                  state_d    = DROP;
               end else begin
                  wr_en          = 1'b1;
                  wr_entry.tlast = wr_last;
                  // Last free slot: close the line here rather than lose its end.
                  if (!wr_last && fifo_cnt == CW'(FIFO_DEPTH - 1)) begin
                     wr_entry.tlast = 1'b1;
                     ovf_set        = 1'b1;
                     state_d        = DROP;
                  end
                  if (wr_entry.tlast) begin
                     line_width_d = pix_cnt_q + CNT_ONE;
                     line_cnt_d   = line_cnt_q + CNT_ONE;
                     pix_cnt_d    = '0;
                     pend_vld_d   = 1'b0;
                  end else begin
                     pix_cnt_d = pix_cnt_q + CNT_ONE;
                  end
               end
            end
            if (cap && state_d == ACTIVE) begin
               pend_vld_d  = 1'b1;
               pend_data_d = pix_ext;
               pend_user_d = sof_q | fval_rise;
               sof_d       = 1'b0;
            end
         end
         DROP: begin
            if (!cap) begin
               state_d = ACTIVE;
            end
         end
         default: state_d = WAIT_SOF;
      endcase

      if (state_q != WAIT_SOF && fval_fall) begin
         frame_lines_d = line_cnt_d;
         frame_cnt_d   = frame_cnt_q + CNT_ONE;
         line_cnt_d    = '0;
         state_d       = ACTIVE;
      end

      ovf_d = ovf_set | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge pixclk) begin
      if (pixrst) begin
         state_q       <= WAIT_SOF;
         ifval_q       <= 1'b1;
         sof_q         <= 1'b0;
         pend_vld_q    <= 1'b0;
         pend_user_q   <= 1'b0;
         pend_data_q   <= '0;
         pix_cnt_q     <= '0;
         line_cnt_q    <= '0;
         line_width_q  <= '0;
         frame_lines_q <= '0;
         frame_cnt_q   <= '0;
         ovf_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         ifval_q       <= ifval;
         sof_q         <= sof_d;
         pend_vld_q    <= pend_vld_d;
         pend_user_q   <= pend_user_d;
         pend_data_q   <= pend_data_d;
         pix_cnt_q     <= pix_cnt_d;
         line_cnt_q    <= line_cnt_d;
         line_width_q  <= line_width_d;
         frame_lines_q <= frame_lines_d;
         frame_cnt_q   <= frame_cnt_d;
         ovf_q         <= ovf_d;
      end
   end

   axis_pixel_fifo #(
      .T     (entry_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (pixclk),
      .rst      (pixrst),
      .wr_en    (wr_en),
      .wr_data  (wr_entry),
      .rd_en    (m_axis_tready),
      .rd_data  (head),
      .rd_valid (head_vld),
      .count    (fifo_cnt)
   );

   assign m_axis_tvalid = head_vld;
   assign m_axis_tdata  = head.data;
   assign m_axis_tuser  = head.tuser;
   assign m_axis_tlast  = head.tlast;
   assign overflow      = ovf_q;
   assign line_width    = line_width_q;
   assign frame_lines   = frame_lines_q;
   assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_d5m_axis_packer.sv
// Directed bench for d5m_axis_packer: cycle table plus multi-cycle sequences.
module tb_d5m_axis_packer;

   logic        pixclk = 1'b0;
   logic        pixrst;
   logic        ifval;
   logic        ilval;
   logic [11:0] idata;
   logic        tready;
   logic        tvalid;
   logic [15:0] tdata;
   logic        tuser;
   logic        tlast;
   logic        ovf_clr;
   logic        overflow;
   logic [15:0] line_width;
   logic [15:0] frame_lines;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        tuser;
      logic        tlast;
      logic [15:0] data;
   } xfer_t;

   typedef struct {
      logic        f;
      logic        l;
      logic [11:0] d;
      logic        ev;
      logic [15:0] ed;
      logic        eu;
      logic        el;
      logic [15:0] lw;
      logic [15:0] fl;
      logic [15:0] fc;
   } vec_t;

   xfer_t got[$];
   xfer_t cx;
   vec_t  tv[$];

   always #5 pixclk = ~pixclk;

   d5m_axis_packer dut (
      .pixclk        (pixclk),
      .pixrst        (pixrst),
      .ifval         (ifval),
      .ilval         (ilval),
      .idata         (idata),
      .m_axis_tready (tready),
      .m_axis_tvalid (tvalid),
      .m_axis_tdata  (tdata),
      .m_axis_tuser  (tuser),
      .m_axis_tlast  (tlast),
      .ovf_clr       (ovf_clr),
      .overflow      (overflow),
      .line_width    (line_width),
      .frame_lines   (frame_lines),
      .frame_cnt     (frame_cnt)
   );

   always @(negedge pixclk) begin
      if (tvalid && tready && !pixrst) begin
         cx.tuser = tuser;
         cx.tlast = tlast;
         cx.data  = tdata;
         got.push_back(cx);
      end
   end

   task automatic tick();
      @(posedge pixclk);
      #1;
   endtask

   task automatic drv(input int f, input int l, input int d);
      ifval = f[0];
      ilval = l[0];
      idata = d[11:0];
      tick();
   endtask

   task automatic line(input int n, input int base);
      for (int i = 0; i < n; i++) drv(1, 1, base + i);
      drv(1, 0, 0);
   endtask

   task automatic check(input string nm, input logic [71:0] g,
                        input logic [71:0] e);
      total++;
      if (g !== e) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, g, e);
      end
   endtask

   task automatic chk_x(input string nm, input int idx, input int d,
                        input int u, input int l);
      if (idx >= got.size()) begin
         total++;
         bad++;
         $display("FAIL %s[%0d] got=missing exp=%0h", nm, idx, d);
      end else begin
         check($sformatf("%s[%0d]", nm, idx),
               72'({got[idx].tuser, got[idx].tlast, got[idx].data}),
               72'({u[0], l[0], d[15:0]}));
      end
   endtask

   task automatic add(input int f, input int l, input int d, input int ev,
                      input int ed, input int eu, input int el,
                      input int lw, input int fl, input int fc);
      vec_t v;
      v.f  = f[0];
      v.l  = l[0];
      v.d  = d[11:0];
      v.ev = ev[0];
      v.ed = ed[15:0];
      v.eu = eu[0];
      v.el = el[0];
      v.lw = lw[15:0];
      v.fl = fl[15:0];
      v.fc = fc[15:0];
      tv.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pixrst  = 1'b1;
      ifval   = 1'b0;
      ilval   = 1'b0;
      idata   = '0;
      tready  = 1'b1;
      ovf_clr = 1'b0;
      repeat (3) tick();
      pixrst = 1'b0;
      tick();
      check("reset", 72'({tvalid, tdata, tuser, tlast, overflow,
                          line_width, frame_lines, frame_cnt}), 72'(0));

      // f l d | ev ed eu el | lw fl fc
      add(0, 0, 0,  0, 0, 0, 0,  0, 0, 0);
      add(1, 0, 0,  0, 0, 0, 0,  0, 0, 0);
      add(1, 1, 1,  0, 0, 0, 0,  0, 0, 0);
      add(1, 1, 2,  0, 0, 0, 0,  0, 0, 0);
      add(1, 1, 3,  1, 1, 1, 0,  0, 0, 0);
      add(1, 1, 4,  1, 2, 0, 0,  0, 0, 0);
      add(1, 0, 0,  1, 3, 0, 0,  4, 0, 0);
      add(1, 0, 0,  1, 4, 0, 1,  4, 0, 0);
      add(1, 1, 5,  0, 0, 0, 0,  4, 0, 0);
      add(1, 1, 6,  0, 0, 0, 0,  4, 0, 0);
      add(1, 1, 7,  1, 5, 0, 0,  4, 0, 0);
      add(1, 1, 8,  1, 6, 0, 0,  4, 0, 0);
      add(1, 0, 0,  1, 7, 0, 0,  4, 0, 0);
      add(0, 0, 0,  1, 8, 0, 1,  4, 2, 1);
      add(0, 0, 0,  0, 0, 0, 0,  4, 2, 1);

      foreach (tv[i]) begin
         ifval = tv[i].f;
         ilval = tv[i].l;
         idata = tv[i].d;
         tick();
         check($sformatf("vec%0d", i),
               72'({tvalid, (tvalid ? {tuser, tlast, tdata} : 18'h0),
                    line_width, frame_lines, frame_cnt}),
               72'({tv[i].ev,
                    (tv[i].ev ? {tv[i].eu, tv[i].el, tv[i].ed} : 18'h0),
                    tv[i].lw, tv[i].fl, tv[i].fc}));
      end

      // backpressure over a 6-pixel line
      got.delete();
      tready = 1'b0;
      drv(1, 0, 0);
      line(6, 1);
      drv(1, 0, 0);
      check("bp_hold1", 72'({tvalid, tuser, tlast, tdata}),
            72'({1'b1, 1'b1, 1'b0, 16'h0001}));
      drv(1, 0, 0);
      drv(1, 0, 0);
      check("bp_hold2", 72'({tvalid, tuser, tlast, tdata}),
            72'({1'b1, 1'b1, 1'b0, 16'h0001}));
      tready = 1'b1;
      repeat (10) drv(1, 0, 0);
      drv(0, 0, 0);
      drv(0, 0, 0);
      check("bp_count", 72'(got.size()), 72'(6));
      for (int i = 0; i < 6; i++) chk_x("bp_px", i, i + 1, int'(i == 0), int'(i == 5));
      check("bp_ovf", 72'(overflow), 72'(0));
      check("bp_fc", 72'(frame_cnt), 72'(2));

      // overflow on a 20-pixel line
      got.delete();
      tready = 1'b0;
      drv(1, 0, 0);
      line(20, 1);
      drv(1, 0, 0);
      check("ov_flag", 72'(overflow), 72'(1));
      check("ov_lw", 72'(line_width), 72'(16));
      tready = 1'b1;
      repeat (24) drv(1, 0, 0);
      check("ov_count", 72'(got.size()), 72'(16));
      chk_x("ov_px", 0, 1, 1, 0);
      chk_x("ov_px", 14, 15, 0, 0);
      chk_x("ov_px", 15, 16, 0, 1);
      got.delete();
      line(4, 'h101);
      repeat (6) drv(1, 0, 0);
      check("ov_next_count", 72'(got.size()), 72'(4));
      chk_x("ov_next", 0, 'h101, 0, 0);
      chk_x("ov_next", 3, 'h104, 0, 1);
      drv(0, 0, 0);
      drv(0, 0, 0);
      check("ov_frame", 72'({line_width, frame_lines, frame_cnt}),
            72'({16'd4, 16'd2, 16'd3}));

      // clear versus set on the same edge
      ovf_clr = 1'b1;
      drv(0, 0, 0);
      ovf_clr = 1'b0;
      check("clr_lone1", 72'(overflow), 72'(0));
      got.delete();
      tready = 1'b0;
      drv(1, 0, 0);
      for (int i = 0; i < 16; i++) drv(1, 1, i + 1);
      check("clr_pre", 72'(overflow), 72'(0));
      ovf_clr = 1'b1;
      drv(1, 1, 17);
      ovf_clr = 1'b0;
      check("clr_vs_set", 72'(overflow), 72'(1));
      drv(1, 0, 0);
      tready = 1'b1;
      repeat (24) drv(1, 0, 0);
      drv(0, 0, 0);
      check("clr_count", 72'(got.size()), 72'(16));
      ovf_clr = 1'b1;
      drv(0, 0, 0);
      ovf_clr = 1'b0;
      check("clr_lone2", 72'(overflow), 72'(0));

      // reset in the middle of line 2
      drv(1, 0, 0);
      line(4, 'h201);
      drv(1, 1, 'h205);
      drv(1, 1, 'h206);
      pixrst = 1'b1;
      drv(1, 1, 'h207);
      drv(1, 1, 'h208);
      pixrst = 1'b0;
      check("rst_state", 72'({tvalid, overflow, line_width, frame_lines,
                              frame_cnt}), 72'(0));
      got.delete();
      drv(1, 1, 'h209);
      drv(1, 1, 'h20a);
      drv(1, 0, 0);
      line(3, 'h210);
      drv(0, 0, 0);
      drv(0, 0, 0);
      check("rst_quiet", 72'(got.size()), 72'(0));
      check("rst_fc0", 72'(frame_cnt), 72'(0));
      drv(1, 0, 0);
      line(2, 'h301);
      line(2, 'h303);
      repeat (5) drv(0, 0, 0);
      check("rst_count", 72'(got.size()), 72'(4));
      chk_x("rst_px", 0, 'h301, 1, 0);
      chk_x("rst_px", 1, 'h302, 0, 1);
      chk_x("rst_px", 3, 'h304, 0, 1);
      check("rst_frame", 72'({frame_lines, frame_cnt}),
            72'({16'd2, 16'd1}));

      // ifval falls while ilval is still high
      got.delete();
      drv(1, 0, 0);
      drv(1, 1, 'h401);
      drv(1, 1, 'h402);
      drv(1, 1, 'h403);
      drv(0, 1, 0);
      repeat (5) drv(0, 0, 0);
      check("fall_count", 72'(got.size()), 72'(3));
      chk_x("fall_px", 0, 'h401, 1, 0);
      chk_x("fall_px", 2, 'h403, 0, 1);
      check("fall_stats", 72'({line_width, frame_lines, frame_cnt}),
            72'({16'd3, 16'd1, 16'd2}));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/d5m_axis_packer.md
Name: d5m_axis_packer

Overview:
- Front-end capture stage directly upstream of the video frame processor's rgb_s_axis receive channel.
- Converts the D5M camera raw bus (ifval/ilval/idata) into an AXI4-Stream video stream: tuser marks start-of-frame, tlast marks end-of-line.
- Absorbs downstream backpressure with an internal pixel FIFO.
- Reports measured line width, lines per frame, frame count and overflow status.

Parameters:
- DATA_WIDTH, 12, camera pixel width (idata).
- TDATA_WIDTH, 16, m_axis_tdata width. Must be >= DATA_WIDTH; pixel is zero-extended in the MSBs.
- FIFO_DEPTH, 16, pixel FIFO entries. Power of two, >= 4.
- CNT_WIDTH, 16, width of width/line/frame counters.

Ports:
- pixclk  in  1  camera pixel clock; sole clock.
- pixrst  in  1  synchronous active-high reset.
- ifval  in  1  frame valid.
- ilval  in  1  line valid.
- idata  in  DATA_WIDTH  raw pixel, valid when ifval&ilval.
- m_axis_tready  in  1  downstream ready.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tdata  out  TDATA_WIDTH  pixel.
- m_axis_tuser  out  1  first pixel of frame.
- m_axis_tlast  out  1  last pixel of line.
- ovf_clr  in  1  clears sticky overflow.
- overflow  out  1  sticky FIFO-overflow flag.
- line_width  out  CNT_WIDTH  pixel count of last completed line.
- frame_lines  out  CNT_WIDTH  line count of last completed frame.
- frame_cnt  out  CNT_WIDTH  completed frames, wraps at 2^CNT_WIDTH.

Behaviour:
- Clock and reset: single clock pixclk; reset pixrst is synchronous, active-high.
- Reset values: all outputs 0; FIFO empty; pending register invalid; state WAIT_SOF; all counters 0.
- States:
  - WAIT_SOF: ignore all input until ifval is sampled 0 then 1 (rising edge), then go to ACTIVE. A reset mid-frame therefore discards the rest of that frame.
  - ACTIVE: capture pixels.
  - DROP: discard pixels until the line ends (ilval or ifval sampled 0), then return to ACTIVE.
- A pixel is captured on each edge with ifval=1 and ilval=1. ilval=1 with ifval=0 is ignored.
- One-deep pending register:
  - A captured pixel is held, not written, until the line's next pixel is captured; it is then written with tlast=0.
  - If instead ilval (or ifval) is sampled 0, it is written with tlast=1.
  - tuser=1 only on the first pixel captured after entering ACTIVE from WAIT_SOF.
- Latency: a write at edge t makes data visible at the FIFO head (tvalid=1) after edge t+1, i.e. a registered first-word-fall-through output.
  - Mid-line pixel: 2 edges from capture to tvalid.
  - Last pixel: 1 edge after ilval is sampled low.
- AXIS rules:
  - Transfer occurs when tvalid&tready.
  - tvalid, tdata, tuser and tlast are held stable while tvalid&!tready.
  - tvalid never drops without a transfer.
- FIFO full handling: decisions use the occupancy count before the edge; a concurrent read is ignored (conservative).
  - count == FIFO_DEPTH-1 and the write is a non-last pixel: write it with tlast forced to 1, set overflow, go to DROP.
  - count == FIFO_DEPTH (full): drop the write, set overflow, go to DROP.
- Simultaneous read and write: both occur; count is unchanged.
- overflow: sticky. Cleared by ovf_clr=1. If a set and a clear coincide, set wins.
- line_width: updated on each tlast write (including forced tlast) with the number of pixels written for that line.
- frame_lines and frame_cnt: on ifval falling in ACTIVE or DROP, frame_lines takes the line count and frame_cnt increments, wrapping. The state then stays ACTIVE, awaiting the next ifval rise, which re-arms tuser.
- ifval falling while ilval=1: treated as end of line, so the pending pixel is flushed with tlast=1.
- Zero-length line (ilval pulse with ifval=0, or no captured pixels): no write, no count update.

Decomposition:
- Shared package (generic_pack), add:
  - typedef pix_entry_t = struct {tuser, tlast, data[TDATA_WIDTH-1:0]};
  - enum capture_state_t {WAIT_SOF, ACTIVE, DROP};
  - default constants D5M_DATA_WIDTH=12, PIX_FIFO_DEPTH=16.
- Sub-module axis_pixel_fifo: synchronous FWFT FIFO of pix_entry_t, with count output, wr_en/rd_en and a registered head.

Test Plan:
- Basic frame, tready=1: 2 lines × 4 pixels, data 0x001..0x008. Expect 8 transfers; tuser only on 0x001; tlast on 0x004 and 0x008; then line_width=4, frame_lines=2, frame_cnt=1.
- Backpressure: tready=0 during a 6-pixel line, FIFO_DEPTH=16. Expect tvalid high and tdata stable at 0x001. On release, all 6 pixels arrive in order, tlast on the 6th, overflow=0.
- Overflow: tready=0, one 20-pixel line, FIFO_DEPTH=16.
  - Expect 16 entries, the 16th with tlast=1.
  - overflow=1 and line_width=16.
  - The next line of 4 is captured normally after the FIFO drains.
- Reset mid-frame: assert pixrst in the middle of line 2, with ifval still high after release. Expect no output until an ifval 0→1 transition; the next frame starts with tuser=1 and frame_cnt=1 after it ends.
- ifval falls with ilval=1 after 3 pixels: expect the 3rd pixel to carry tlast=1, line_width=3 and frame_cnt incremented.
- ovf_clr pulsed in the same cycle as a new overflow event: expect overflow to remain 1. A later lone ovf_clr clears it to 0.
